// File: rtl/vga_demo_pkg.sv
// Shared VGA demo constants and types: active area, sprite palette, motion direction.
package vga_demo_pkg;

  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;

  typedef logic [5:0] rgb6_t;

  typedef enum logic {FWD = 1'b0, REV = 1'b1} dir_t;

  localparam rgb6_t PALETTE [8] = '{6'h30, 6'h0C, 6'h03, 6'h3C, 6'h0F, 6'h33, 6'h3F, 6'h15};

  function automatic rgb6_t checker_rgb(input logic h_bit, input logic v_bit);
    return (h_bit ^ v_bit) ? 6'b000001 : 6'b000000;
  endfunction

endpackage

// File: rtl/bounce_axis.sv
// One motion axis of the sprite: moves by step per strobe between 0 and LIMIT.
module bounce_axis
  import vga_demo_pkg::*;
#(
  parameter int LIMIT = 608,
  parameter int INIT  = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       strobe,
  input  logic [2:0] step,
  output logic [9:0] pos,
  output logic       bounce
);

  localparam logic [10:0] LIM = 11'(LIMIT);

  dir_t        dir_q;
  logic [10:0] pos_q;
  logic        bounce_q;
  logic [10:0] step_w;

  assign step_w = {8'd0, step};

  // FWD/REV state machine; 11-bit math keeps pos+step from wrapping near the limit
  always_ff @(posedge clk) begin
    if (reset) begin
      pos_q    <= 11'(INIT);
      dir_q    <= FWD;
      bounce_q <= 1'b0;
    end else begin
      bounce_q <= 1'b0;
      if (strobe) begin
        case (dir_q)
          FWD: begin
            if (pos_q + step_w >= LIM) begin
              pos_q    <= LIM;
              dir_q    <= REV;
              bounce_q <= 1'b1;
            end else begin
              pos_q <= pos_q + step_w;
            end
          end
          REV: begin
            if (pos_q <= step_w) begin
              pos_q    <= 11'd0;
              dir_q    <= FWD;
              bounce_q <= 1'b1;
            end else begin
              pos_q <= pos_q - step_w;
            end
          end
          default: begin
            dir_q <= FWD;
          end
        endcase
      end
    end
  end

  assign pos    = pos_q[9:0];
  assign bounce = bounce_q;

endmodule

// File: rtl/bounce_sprite_renderer.sv
// Pixel-colour stage: bouncing sprite over a checkerboard, registered RGB with
// syncs delayed to stay aligned with the colour.
module bounce_sprite_renderer
  import vga_demo_pkg::*;
#(
  parameter int H_ACT  = H_ACTIVE,
  parameter int V_ACT  = V_ACTIVE,
  parameter int BOX_W  = 32,
  parameter int BOX_H  = 32,
  parameter int X_INIT = 64,
  parameter int Y_INIT = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] hpos,
  input  logic [9:0] vpos,
  input  logic       display_on,
  input  logic       hsync_in,
  input  logic       vsync_in,
  input  logic [1:0] speed_sel,
  input  logic       pause,
  output logic [5:0] rgb_out,
  output logic       hsync_out,
  output logic       vsync_out,
  output logic [7:0] bounce_count
);

  logic       strobe;
  logic [2:0] step;
  logic [9:0] box_x, box_y;
  logic       bounce_x, bounce_y;
  logic [1:0] bounce_inc;
  logic       in_box;
  rgb6_t      rgb_d;

  rgb6_t      rgb_q;
  logic       hsync_q, vsync_q;
  logic [2:0] color_idx_q;
  logic [7:0] bounce_count_q;

  // First pixel of the first blanking line: motion updates land outside the visible frame
  assign strobe = (hpos == 10'd0) && (vpos == 10'(V_ACT)) && !pause;
  assign step   = {1'b0, speed_sel} + 3'd1;

  bounce_axis #(.LIMIT(H_ACT - BOX_W), .INIT(X_INIT)) u_axis_x (
    .clk    (clk),
    .reset  (reset),
    .strobe (strobe),
    .step   (step),
    .pos    (box_x),
    .bounce (bounce_x)
  );

  bounce_axis #(.LIMIT(V_ACT - BOX_H), .INIT(Y_INIT)) u_axis_y (
    .clk    (clk),
    .reset  (reset),
    .strobe (strobe),
    .step   (step),
    .pos    (box_y),
    .bounce (bounce_y)
  );

  assign bounce_inc = {1'b0, bounce_x} + {1'b0, bounce_y};

  assign in_box = ({1'b0, hpos} >= {1'b0, box_x}) &&
                  ({1'b0, hpos} <  {1'b0, box_x} + 11'(BOX_W)) &&
                  ({1'b0, vpos} >= {1'b0, box_y}) &&
                  ({1'b0, vpos} <  {1'b0, box_y} + 11'(BOX_H));

  // Pixel colour selection
  always_comb begin
    rgb_d = 6'b000000;
    if (!display_on) begin
      rgb_d = 6'b000000;
    end else if (in_box) begin
      rgb_d = PALETTE[color_idx_q];
    end else begin
      rgb_d = checker_rgb(hpos[5], vpos[5]);
    end
  end

  // Output pipeline plus colour/bounce bookkeeping
  always_ff @(posedge clk) begin
    if (reset) begin
      rgb_q          <= 6'b000000;
      hsync_q        <= 1'b0;
      vsync_q        <= 1'b0;
      color_idx_q    <= 3'd0;
      bounce_count_q <= 8'd0;
    end else begin
      rgb_q          <= rgb_d;
      hsync_q        <= hsync_in;
      vsync_q        <= vsync_in;
      color_idx_q    <= color_idx_q + {1'b0, bounce_inc};
      bounce_count_q <= bounce_count_q + {6'd0, bounce_inc};
    end
  end

  assign rgb_out      = rgb_q;
  assign hsync_out    = hsync_q;
  assign vsync_out    = vsync_q;
  assign bounce_count = bounce_count_q;

endmodule
